// File: rtl/l2_wb_cache.sv
// l2_wb_cache: write-back, write-allocate set-associative line cache with one outstanding request.
// Request side: i_req_valid/o_req_ready handshake carrying i_addr, i_op (0 read, 1 write), i_wdata, i_wstrb;
//   response is a one-cycle o_rsp_valid pulse with o_rdata (final line) and o_hit.
// Memory side: o_mem_rreq/o_mem_raddr/i_mem_rdone/i_mem_rdata line fill, o_mem_wreq/o_mem_waddr/o_mem_wdata/i_mem_wdone write-back.
// Replacement: define L2_WB_CACHE_PLRU_EN for per-set tree pseudo-LRU, otherwise a global round-robin counter.
module l2_wb_cache #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_BITS  = 256,
  parameter int NUM_SETS   = 16,
  parameter int NUM_WAYS   = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_req_valid,
  output logic                    o_req_ready,
  input  logic [ADDR_WIDTH-1:0]   i_addr,
  input  logic                    i_op,
  input  logic [LINE_BITS-1:0]    i_wdata,
  input  logic [LINE_BITS/8-1:0]  i_wstrb,
  output logic                    o_rsp_valid,
  output logic [LINE_BITS-1:0]    o_rdata,
  output logic                    o_hit,
  output logic                    o_mem_rreq,
  output logic [ADDR_WIDTH-1:0]   o_mem_raddr,
  input  logic                    i_mem_rdone,
  input  logic [LINE_BITS-1:0]    i_mem_rdata,
  output logic                    o_mem_wreq,
  output logic [ADDR_WIDTH-1:0]   o_mem_waddr,
  output logic [LINE_BITS-1:0]    o_mem_wdata,
  input  logic                    i_mem_wdone
);
  localparam int BYTES = LINE_BITS / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int WAY_W = $clog2(NUM_WAYS);
  localparam int LA_W  = ADDR_WIDTH - OFF_W;
  localparam int TAG_W = LA_W - IDX_W;

  typedef enum logic [2:0] {IDLE, LOOKUP, EVICT, FILL, UPDATE, RESP} state_t;

  state_t               state_q, state_d;
  logic [LA_W-1:0]      laddr_q, laddr_d;
  logic                 op_q, op_d, hit_q, hit_d;
  logic [LINE_BITS-1:0] wdata_q, wdata_d, line_q, line_d, merged;
  logic [BYTES-1:0]     wstrb_q, wstrb_d;
  logic [WAY_W-1:0]     way_q, way_d, hit_way, inv_way, vict_way;
  logic [TAG_W-1:0]     tag_q [NUM_SETS][NUM_WAYS], tag_d [NUM_SETS][NUM_WAYS];
  logic [LINE_BITS-1:0] data_q [NUM_SETS][NUM_WAYS], data_d [NUM_SETS][NUM_WAYS];
  logic [NUM_WAYS-1:0]  valid_q [NUM_SETS], valid_d [NUM_SETS];
  logic [NUM_WAYS-1:0]  dirty_q [NUM_SETS], dirty_d [NUM_SETS];
  logic [IDX_W-1:0]     idx;
  logic [TAG_W-1:0]     tag;
  logic                 hit_any, inv_any, unused_off;

  assign idx        = laddr_q[IDX_W-1:0];
  assign tag        = laddr_q[LA_W-1:IDX_W];
  assign unused_off = ^i_addr[OFF_W-1:0];

`ifdef L2_WB_CACHE_PLRU_EN
  // Tree node n (heap numbering from 1) lives in bit n-1; a bit of 1 points the victim search to the right child.
  logic [NUM_WAYS-2:0] plru_q [NUM_SETS], plru_d [NUM_SETS];

  function automatic logic [WAY_W-1:0] plru_victim(input logic [NUM_WAYS-2:0] t);
    int n = 1;
    for (int l = 0; l < WAY_W; l++) n = 2 * n + int'(t[n-1]);
    return WAY_W'(n - NUM_WAYS);
  endfunction

  function automatic logic [NUM_WAYS-2:0] plru_touch(input logic [NUM_WAYS-2:0] t, input logic [WAY_W-1:0] w);
    int n = 1;
    logic b;
    for (int l = 0; l < WAY_W; l++) begin
      b = w[WAY_W-1-l];
      t[n-1] = ~b;
      n = 2 * n + int'(b);
    end
    return t;
  endfunction

  assign vict_way = inv_any ? inv_way : plru_victim(plru_q[idx]);
`else
  logic [WAY_W-1:0] rr_q, rr_d;
  assign vict_way = inv_any ? inv_way : rr_q;
`endif

  always_comb begin
    hit_any = 1'b0;
    hit_way = '0;
    inv_any = 1'b0;
    inv_way = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (valid_q[idx][w] && tag_q[idx][w] == tag && !hit_any) begin
        hit_any = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid_q[idx][w] && !inv_any) begin
        inv_any = 1'b1;
        inv_way = WAY_W'(w);
      end
    end
  end

  always_comb begin
    merged = line_q;
    for (int b = 0; b < BYTES; b++)
      merged[8*b +: 8] = (op_q && wstrb_q[b]) ? wdata_q[8*b +: 8] : line_q[8*b +: 8];
  end

  always_comb begin
    state_d = state_q;
    laddr_d = laddr_q;
    op_d    = op_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    hit_d   = hit_q;
    way_d   = way_q;
    line_d  = line_q;
    tag_d   = tag_q;
    data_d  = data_q;
    valid_d = valid_q;
    dirty_d = dirty_q;
`ifdef L2_WB_CACHE_PLRU_EN
    plru_d  = plru_q;
`else
    rr_d    = rr_q;
`endif
    case (state_q)
      IDLE: if (i_req_valid) begin
        laddr_d = i_addr[ADDR_WIDTH-1:OFF_W];
        op_d    = i_op;
        wdata_d = i_wdata;
        wstrb_d = i_wstrb;
        state_d = LOOKUP;
      end
      LOOKUP: begin
        hit_d = hit_any;
        if (hit_any) begin
          way_d   = hit_way;
          line_d  = data_q[idx][hit_way];
          state_d = op_q ? UPDATE : RESP;
        end else begin
          way_d   = vict_way;
          state_d = (valid_q[idx][vict_way] && dirty_q[idx][vict_way]) ? EVICT : FILL;
`ifndef L2_WB_CACHE_PLRU_EN
          if (!inv_any) rr_d = WAY_W'(rr_q + 1'b1);
`endif
        end
      end
      EVICT: if (i_mem_wdone) state_d = FILL;
      FILL: if (i_mem_rdone) begin
        line_d  = i_mem_rdata;
        state_d = UPDATE;
      end
      UPDATE: begin
        line_d              = merged;
        data_d[idx][way_q]  = merged;
        tag_d[idx][way_q]   = tag;
        valid_d[idx][way_q] = 1'b1;
        dirty_d[idx][way_q] = op_q | (hit_q & dirty_q[idx][way_q]);
        state_d             = RESP;
      end
      RESP: begin
        // Every completed request was either a hit or a fill of way_q, so the tree is touched here once.
`ifdef L2_WB_CACHE_PLRU_EN
        plru_d[idx] = plru_touch(plru_q[idx], way_q);
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      laddr_q <= '0;
      op_q    <= 1'b0;
      wdata_q <= '0;
      wstrb_q <= '0;
      hit_q   <= 1'b0;
      way_q   <= '0;
      line_q  <= '0;
      valid_q <= '{default: '0};
      dirty_q <= '{default: '0};
`ifdef L2_WB_CACHE_PLRU_EN
      plru_q  <= '{default: '0};
`else
      rr_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      laddr_q <= laddr_d;
      op_q    <= op_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      hit_q   <= hit_d;
      way_q   <= way_d;
      line_q  <= line_d;
      valid_q <= valid_d;
      dirty_q <= dirty_d;
`ifdef L2_WB_CACHE_PLRU_EN
      plru_q  <= plru_d;
`else
      rr_q    <= rr_d;
`endif
    end
  end

  always_ff @(posedge i_clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

  assign o_req_ready = state_q == IDLE;
  assign o_rsp_valid = state_q == RESP;
  assign o_rdata     = o_rsp_valid ? line_q : '0;
  assign o_hit       = o_rsp_valid & hit_q;
  assign o_mem_rreq  = state_q == FILL;
  assign o_mem_raddr = o_mem_rreq ? {laddr_q, {OFF_W{1'b0}}} : '0;
  assign o_mem_wreq  = state_q == EVICT;
  assign o_mem_waddr = o_mem_wreq ? {tag_q[idx][way_q], idx, {OFF_W{1'b0}}} : '0;
  assign o_mem_wdata = o_mem_wreq ? data_q[idx][way_q] : '0;
endmodule

// File: tb/tb_l2_wb_cache.sv
// tb_l2_wb_cache: directed self-checking bench for l2_wb_cache with a 3-cycle memory responder.
module tb_l2_wb_cache;
  logic         i_clk = 1'b0;
  logic         i_rst_n = 1'b0;
  logic         i_req_valid = 1'b0;
  logic         o_req_ready;
  logic [31:0]  i_addr = '0;
  logic         i_op = 1'b0;
  logic [255:0] i_wdata = '0;
  logic [31:0]  i_wstrb = '0;
  logic         o_rsp_valid;
  logic [255:0] o_rdata;
  logic         o_hit;
  logic         o_mem_rreq;
  logic [31:0]  o_mem_raddr;
  logic         i_mem_rdone = 1'b0;
  logic [255:0] i_mem_rdata = '0;
  logic         o_mem_wreq;
  logic [31:0]  o_mem_waddr;
  logic [255:0] o_mem_wdata;
  logic         i_mem_wdone = 1'b0;

  int checks = 0;
  int errors = 0;
  int n_rreq, n_wreq, first_rreq, first_wreq;
  logic [31:0]  last_raddr, last_waddr;
  logic [255:0] last_wdata;

  localparam logic [255:0] LINE_A5 = {32{8'hA5}};
  localparam logic [255:0] LINE_3C = {{31{8'hA5}}, 8'h3C};
  localparam logic [255:0] LINE_55 = {32{8'h55}};

  always #5 i_clk = ~i_clk;

  l2_wb_cache dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_addr(i_addr), .i_op(i_op), .i_wdata(i_wdata), .i_wstrb(i_wstrb),
    .o_rsp_valid(o_rsp_valid), .o_rdata(o_rdata), .o_hit(o_hit),
    .o_mem_rreq(o_mem_rreq), .o_mem_raddr(o_mem_raddr), .i_mem_rdone(i_mem_rdone), .i_mem_rdata(i_mem_rdata),
    .o_mem_wreq(o_mem_wreq), .o_mem_waddr(o_mem_waddr), .o_mem_wdata(o_mem_wdata), .i_mem_wdone(i_mem_wdone)
  );

  task automatic do_reset();
    i_rst_n = 1'b0;
    i_req_valid = 1'b0;
    i_mem_rdone = 1'b0;
    i_mem_wdone = 1'b0;
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  // lat counts falling edges after the accepting rising edge up to the one that sees o_rsp_valid.
  task automatic xact(input logic [31:0] a, input logic op, input logic [255:0] wd, input logic [31:0] ws,
                      input logic [255:0] fill, output int lat, output logic hit, output logic [255:0] rd);
    int rc = 0, wc = 0;
    bit done = 0;
    n_rreq = 0; n_wreq = 0; first_rreq = 0; first_wreq = 0;
    last_raddr = '0; last_waddr = '0; last_wdata = '0;
    hit = 1'b0; rd = '0; lat = 0;
    @(negedge i_clk);
    i_req_valid = 1'b1; i_addr = a; i_op = op; i_wdata = wd; i_wstrb = ws;
    @(posedge i_clk);
    #1 i_req_valid = 1'b0;
    while (!done && lat < 100) begin
      @(negedge i_clk);
      lat++;
      i_mem_rdone = 1'b0;
      i_mem_wdone = 1'b0;
      checks++;
      if ((o_mem_rreq && o_mem_wreq) || (!o_mem_rreq && o_mem_raddr !== 32'h0) ||
          (!o_mem_wreq && (o_mem_waddr !== 32'h0 || o_mem_wdata !== 256'h0)) ||
          (!o_rsp_valid && (o_rdata !== 256'h0 || o_hit !== 1'b0))) begin
        errors++;
        $display("FAIL strobe_qual: rreq=%b wreq=%b raddr=%h waddr=%h rsp=%b hit=%b, required unqualified outputs 0 and no dual request",
                 o_mem_rreq, o_mem_wreq, o_mem_raddr, o_mem_waddr, o_rsp_valid, o_hit);
      end
      if (o_rsp_valid) begin
        done = 1;
        hit = o_hit;
        rd = o_rdata;
      end else if (o_mem_wreq) begin
        n_wreq++;
        if (first_wreq == 0) first_wreq = lat;
        last_waddr = o_mem_waddr;
        last_wdata = o_mem_wdata;
        wc++;
        if (wc == 3) i_mem_wdone = 1'b1;
      end else if (o_mem_rreq) begin
        n_rreq++;
        if (first_rreq == 0) first_rreq = lat;
        last_raddr = o_mem_raddr;
        rc++;
        if (rc == 3) begin
          i_mem_rdone = 1'b1;
          i_mem_rdata = fill;
        end
      end
    end
    if (!done) begin
      errors++;
      $display("FAIL rsp_timeout: no o_rsp_valid for addr %h within 100 cycles", a);
    end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if (o_req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b, required 1", o_req_ready); end
    checks++;
    if (o_rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp: got %b, required 0", o_rsp_valid); end
    checks++;
    if ({o_mem_rreq, o_mem_wreq} !== 2'b00) begin errors++; $display("FAIL reset_mem: got %b, required 00", {o_mem_rreq, o_mem_wreq}); end
    checks++;
    if (o_hit !== 1'b0 || o_rdata !== 256'h0) begin errors++; $display("FAIL reset_rsp_data: hit=%b rdata=%h, required 0", o_hit, o_rdata); end
  endtask

  task automatic test_read_miss();
    int lat; logic hit; logic [255:0] rd;
    xact(32'h40, 1'b0, '0, '0, LINE_A5, lat, hit, rd);
    checks++;
    if (last_raddr !== 32'h40 || n_rreq !== 3) begin errors++; $display("FAIL miss_raddr: got %h over %0d cycles, required 00000040 over 3", last_raddr, n_rreq); end
    checks++;
    if (hit !== 1'b0) begin errors++; $display("FAIL miss_hit: got %b, required 0", hit); end
    checks++;
    if (rd !== LINE_A5) begin errors++; $display("FAIL miss_rdata: got %h, required %h", rd, LINE_A5); end
    checks++;
    if (lat !== 6) begin errors++; $display("FAIL miss_latency: got %0d, required 6", lat); end
  endtask

  task automatic test_read_hit();
    int lat; logic hit; logic [255:0] rd;
    xact(32'h40, 1'b0, '0, '0, LINE_55, lat, hit, rd);
    checks++;
    if (hit !== 1'b1 || n_rreq !== 0) begin errors++; $display("FAIL rhit_hit: got hit=%b rreq_cycles=%0d, required 1 and 0", hit, n_rreq); end
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL rhit_latency: got %0d, required 2", lat); end
    checks++;
    if (rd !== LINE_A5) begin errors++; $display("FAIL rhit_rdata: got %h, required %h", rd, LINE_A5); end
  endtask

  task automatic test_write_hit();
    int lat; logic hit; logic [255:0] rd;
    xact(32'h40, 1'b1, 256'h3C, 32'h1, LINE_55, lat, hit, rd);
    checks++;
    if (hit !== 1'b1) begin errors++; $display("FAIL whit_hit: got %b, required 1", hit); end
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL whit_latency: got %0d, required 3", lat); end
    checks++;
    if (rd !== LINE_3C) begin errors++; $display("FAIL whit_rdata: got %h, required %h", rd, LINE_3C); end
  endtask

  task automatic test_evict();
    int lat; logic hit; logic [255:0] rd;
    xact(32'h240, 1'b0, '0, '0, {32{8'h11}}, lat, hit, rd);
    xact(32'h440, 1'b0, '0, '0, {32{8'h22}}, lat, hit, rd);
    xact(32'h640, 1'b0, '0, '0, {32{8'h33}}, lat, hit, rd);
    checks++;
    if (hit !== 1'b0 || n_wreq !== 0) begin errors++; $display("FAIL evict_prefill: got hit=%b wreq_cycles=%0d, required 0 and 0", hit, n_wreq); end
    xact(32'h840, 1'b0, '0, '0, LINE_55, lat, hit, rd);
    checks++;
    if (last_waddr !== 32'h40 || n_wreq !== 3) begin errors++; $display("FAIL evict_waddr: got %h over %0d cycles, required 00000040 over 3", last_waddr, n_wreq); end
    checks++;
    if (last_wdata !== LINE_3C) begin errors++; $display("FAIL evict_wdata: got %h, required %h", last_wdata, LINE_3C); end
    checks++;
    if (!(first_wreq > 0 && first_rreq > first_wreq) || last_raddr !== 32'h840) begin
      errors++; $display("FAIL evict_order: wreq@%0d rreq@%0d raddr=%h, required wreq before rreq and raddr 00000840", first_wreq, first_rreq, last_raddr);
    end
    checks++;
    if (hit !== 1'b0 || rd !== LINE_55) begin errors++; $display("FAIL evict_rsp: got hit=%b rdata=%h, required 0 and %h", hit, rd, LINE_55); end
    checks++;
    if (lat !== 9) begin errors++; $display("FAIL evict_latency: got %0d, required 9", lat); end
  endtask

  // Set 3: tags 0..3 fill ways 0..3, tag 0 is hit again, then tag 4 misses.
  task automatic test_replacement();
    int lat; logic hit; logic [255:0] rd;
    logic exp_keep;
`ifdef L2_WB_CACHE_PLRU_EN
    exp_keep = 1'b1;
`else
    exp_keep = 1'b0;
`endif
    do_reset();
    for (int t = 0; t < 4; t++) xact((t << 9) | 32'h60, 1'b0, '0, '0, {32{8'(t)}}, lat, hit, rd);
    xact(32'h60, 1'b0, '0, '0, LINE_55, lat, hit, rd);
    checks++;
    if (hit !== 1'b1) begin errors++; $display("FAIL repl_rehit: got %b, required 1", hit); end
    xact(32'h860, 1'b0, '0, '0, LINE_55, lat, hit, rd);
    checks++;
    if (hit !== 1'b0 || n_wreq !== 0) begin errors++; $display("FAIL repl_miss: got hit=%b wreq_cycles=%0d, required 0 and 0", hit, n_wreq); end
    xact(32'h60, 1'b0, '0, '0, LINE_55, lat, hit, rd);
    checks++;
    if (hit !== exp_keep) begin errors++; $display("FAIL repl_way0: got hit=%b, required %b", hit, exp_keep); end
    xact(32'h260, 1'b0, '0, '0, LINE_55, lat, hit, rd);
    checks++;
    if (hit !== exp_keep) begin errors++; $display("FAIL repl_way1: got hit=%b, required %b", hit, exp_keep); end
  endtask

  task automatic test_reset_mid_fill();
    int lat; logic hit; logic [255:0] rd;
    bit seen = 0, rsp = 0;
    do_reset();
    xact(32'h40, 1'b0, '0, '0, LINE_A5, lat, hit, rd);
    xact(32'h40, 1'b0, '0, '0, LINE_55, lat, hit, rd);
    checks++;
    if (hit !== 1'b1) begin errors++; $display("FAIL mid_prehit: got %b, required 1", hit); end
    @(negedge i_clk);
    i_req_valid = 1'b1; i_addr = 32'h2040; i_op = 1'b0;
    @(posedge i_clk);
    #1 i_req_valid = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge i_clk);
      seen = o_mem_rreq;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL mid_fill_entry: o_mem_rreq got 0, required 1"); end
    #2 i_rst_n = 1'b0;
    #1;
    checks++;
    if (o_mem_rreq !== 1'b0 || o_req_ready !== 1'b1 || o_rsp_valid !== 1'b0) begin
      errors++; $display("FAIL mid_reset: rreq=%b ready=%b rsp=%b, required 0 1 0", o_mem_rreq, o_req_ready, o_rsp_valid);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      rsp |= o_rsp_valid;
    end
    i_rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      rsp |= o_rsp_valid;
    end
    checks++;
    if (rsp) begin errors++; $display("FAIL mid_no_rsp: o_rsp_valid got 1, required 0"); end
    xact(32'h40, 1'b0, '0, '0, LINE_A5, lat, hit, rd);
    checks++;
    if (hit !== 1'b0 || n_rreq !== 3) begin errors++; $display("FAIL mid_post_miss: got hit=%b rreq_cycles=%0d, required 0 and 3", hit, n_rreq); end
  endtask

  task automatic test_stray_done();
    int lat; logic hit; logic [255:0] rd;
    bit bad = 0;
    @(negedge i_clk);
    i_mem_rdone = 1'b1; i_mem_wdone = 1'b1; i_mem_rdata = LINE_55;
    @(negedge i_clk);
    i_mem_rdone = 1'b0; i_mem_wdone = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bad |= (o_req_ready !== 1'b1) || (o_rsp_valid !== 1'b0) || o_mem_rreq || o_mem_wreq;
      @(negedge i_clk);
    end
    checks++;
    if (bad) begin errors++; $display("FAIL stray_idle: ready/rsp/rreq/wreq changed, required 1/0/0/0 throughout"); end
    xact(32'h40, 1'b0, '0, '0, LINE_55, lat, hit, rd);
    checks++;
    if (hit !== 1'b1 || lat !== 2 || rd !== LINE_A5) begin
      errors++; $display("FAIL stray_hit: got hit=%b lat=%0d rdata=%h, required 1 2 %h", hit, lat, rd, LINE_A5);
    end
  endtask

  initial begin
    test_reset();
    test_read_miss();
    test_read_hit();
    test_write_hit();
    test_evict();
    test_replacement();
    test_reset_mid_fill();
    test_stray_done();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
